// File: rtl/pingpong_pkg.sv
// Shared encodings and width helper for the ping-pong stream buffer.
// Read-side FSM states, bank occupancy flags and a minimum-one-bit clog2.
package pingpong_pkg;

    localparam logic [1:0] RD_IDLE   = 2'd0;
    localparam logic [1:0] RD_FETCH  = 2'd1;
    localparam logic [1:0] RD_STREAM = 2'd2;

    localparam logic BANK_FREE = 1'b0;
    localparam logic BANK_FULL = 1'b1;

    // Never returns 0 so the result is always usable as a vector width.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(n)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/pp_bank_ram.sv
// Simple dual-port bank RAM: one write port, one registered read port.
// Address is the concatenation {bank, word address}; contents are never reset.
module pp_bank_ram
    import pingpong_pkg::*;
#(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 9,
    parameter int unsigned BW    = 1,
    parameter int unsigned NBANK = 2
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [BW-1:0]    wbank_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             re_i,
    input  logic [BW-1:0]    rbank_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    localparam int unsigned Words = NBANK << AW;

    logic [WIDTH-1:0]   mem_q [Words];
    logic [WIDTH-1:0]   rdata_q;
    logic [BW+AW-1:0]   wa;
    logic [BW+AW-1:0]   ra;

    assign wa = {wbank_i, waddr_i};
    assign ra = {rbank_i, raddr_i};

    // The read register only moves on re_i, so it doubles as the held word.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[wa] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[ra];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/pingpong_stream_buf.sv
// N-bank ping-pong frame buffer: fills one bank with DIN_W words while a full bank
// drains as DOUT_W beats, most significant slice first.
module pingpong_stream_buf
    import pingpong_pkg::*;
#(
    parameter int unsigned DIN_W     = 32,
    parameter int unsigned DOUT_W    = 8,
    parameter int unsigned DEPTH     = 512,
    parameter int unsigned NBANK     = 2,
    parameter bit          DROP_MODE = 1'b0
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         clr_i,
    input  logic                         in_valid_i,
    input  logic [DIN_W-1:0]             in_data_i,
    output logic                         in_ready_o,
    output logic                         out_valid_o,
    output logic [DOUT_W-1:0]            out_data_o,
    input  logic                         out_ready_i,
    output logic                         out_last_o,
    output logic [clog2(NBANK)-1:0]      wr_bank_o,
    output logic [clog2(NBANK)-1:0]      rd_bank_o,
    output logic [clog2(NBANK+1)-1:0]    banks_full_o,
    output logic [15:0]                  ovf_cnt_o
);

    localparam int unsigned RATIO = DIN_W / DOUT_W;
    localparam int unsigned AW    = clog2(DEPTH);
    localparam int unsigned BW    = clog2(NBANK);
    localparam int unsigned FW    = clog2(NBANK + 1);
    localparam int unsigned KW    = clog2(RATIO);

    localparam logic [AW-1:0] LastAddr = AW'(DEPTH - 1);
    localparam logic [KW-1:0] LastBeat = KW'(RATIO - 1);
    localparam logic [BW-1:0] LastBank = BW'(NBANK - 1);

    if ((DIN_W % DOUT_W) != 0 || DIN_W < DOUT_W) begin : g_bad_ratio
        $error("DIN_W must be an integer multiple of DOUT_W");
    end
    if (DEPTH < 2 || NBANK < 2) begin : g_bad_size
        $error("DEPTH and NBANK must both be at least 2");
    end

    // Write side state
    logic [BW-1:0]    wr_bank_q, wr_bank_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [NBANK-1:0] bank_state_q, bank_state_d;
    logic [FW-1:0]    full_cnt_q, full_cnt_d;
    logic [15:0]      ovf_cnt_q, ovf_cnt_d;

    // Read side state
    logic [1:0]       rd_state_q, rd_state_d;
    logic [BW-1:0]    rd_bank_q, rd_bank_d;
    logic [AW-1:0]    rd_addr_q, rd_addr_d;
    logic [KW-1:0]    beat_q, beat_d;

    logic             wr_bank_free;
    logic             wr_en;
    logic             drop;
    logic             fill;
    logic             streaming;
    logic             beat_hs;
    logic             word_done;
    logic             bank_done;
    logic [BW-1:0]    next_wr_bank;
    logic [BW-1:0]    next_rd_bank;

    logic             ram_re;
    logic [AW-1:0]    ram_raddr;
    logic [DIN_W-1:0] ram_rdata;
    logic [KW-1:0]    slice_idx;
    logic [31:0]      slice_shift;
    logic [DIN_W-1:0] shifted;

    assign wr_bank_free = (bank_state_q[wr_bank_q] == BANK_FREE);
    assign wr_en        = in_valid_i & wr_bank_free;
    assign drop         = in_valid_i & ~wr_bank_free & DROP_MODE;
    assign fill         = wr_en & (wr_addr_q == LastAddr);

    assign streaming    = (rd_state_q == RD_STREAM);
    assign beat_hs      = streaming & out_ready_i;
    assign word_done    = beat_hs & (beat_q == LastBeat);
    assign bank_done    = word_done & (rd_addr_q == LastAddr);

    assign next_wr_bank = (wr_bank_q == LastBank) ? '0 : wr_bank_q + 1'b1;
    assign next_rd_bank = (rd_bank_q == LastBank) ? '0 : rd_bank_q + 1'b1;

    // Write pointer, bank flags and overflow counter
    always_comb begin
        wr_bank_d    = wr_bank_q;
        wr_addr_d    = wr_addr_q;
        bank_state_d = bank_state_q;
        full_cnt_d   = full_cnt_q;
        ovf_cnt_d    = ovf_cnt_q;

        if (wr_en) begin
            if (fill) begin
                wr_addr_d = '0;
                wr_bank_d = next_wr_bank;
            end else begin
                wr_addr_d = wr_addr_q + 1'b1;
            end
        end

        // Fill and free always target different banks, so both may apply together.
        if (fill) begin
            bank_state_d[wr_bank_q] = BANK_FULL;
        end
        if (bank_done) begin
            bank_state_d[rd_bank_q] = BANK_FREE;
        end

        case ({fill, bank_done})
            2'b10:   full_cnt_d = full_cnt_q + 1'b1;
            2'b01:   full_cnt_d = full_cnt_q - 1'b1;
            default: full_cnt_d = full_cnt_q;
        endcase

        if (drop && (ovf_cnt_q != 16'hFFFF)) begin
            ovf_cnt_d = ovf_cnt_q + 16'd1;
        end
    end

    // Read FSM
    always_comb begin
        rd_state_d = rd_state_q;
        rd_bank_d  = rd_bank_q;
        rd_addr_d  = rd_addr_q;
        beat_d     = beat_q;
        ram_re     = 1'b0;
        ram_raddr  = rd_addr_q;

        case (rd_state_q)
            RD_IDLE: begin
                if (bank_state_q[rd_bank_q] == BANK_FULL) begin
                    rd_state_d = RD_FETCH;
                end
            end
            RD_FETCH: begin
                ram_re     = 1'b1;
                ram_raddr  = '0;
                rd_addr_d  = '0;
                beat_d     = '0;
                rd_state_d = RD_STREAM;
            end
            RD_STREAM: begin
                if (beat_hs) begin
                    if (!word_done) begin
                        beat_d = beat_q + 1'b1;
                    end else if (!bank_done) begin
                        // Fetch the next word on the last slice so beats stay back-to-back.
                        ram_re    = 1'b1;
                        ram_raddr = rd_addr_q + 1'b1;
                        rd_addr_d = rd_addr_q + 1'b1;
                        beat_d    = '0;
                    end else begin
                        rd_bank_d  = next_rd_bank;
                        rd_state_d = (bank_state_q[next_rd_bank] == BANK_FULL) ? RD_FETCH
                                                                                : RD_IDLE;
                    end
                end
            end
            default: begin
                rd_state_d = RD_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_bank_q    <= '0;
            wr_addr_q    <= '0;
            bank_state_q <= '0;
            full_cnt_q   <= '0;
            ovf_cnt_q    <= '0;
            rd_state_q   <= RD_IDLE;
            rd_bank_q    <= '0;
            rd_addr_q    <= '0;
            beat_q       <= '0;
        end else if (clr_i) begin
            wr_bank_q    <= '0;
            wr_addr_q    <= '0;
            bank_state_q <= '0;
            full_cnt_q   <= '0;
            ovf_cnt_q    <= '0;
            rd_state_q   <= RD_IDLE;
            rd_bank_q    <= '0;
            rd_addr_q    <= '0;
            beat_q       <= '0;
        end else begin
            wr_bank_q    <= wr_bank_d;
            wr_addr_q    <= wr_addr_d;
            bank_state_q <= bank_state_d;
            full_cnt_q   <= full_cnt_d;
            ovf_cnt_q    <= ovf_cnt_d;
            rd_state_q   <= rd_state_d;
            rd_bank_q    <= rd_bank_d;
            rd_addr_q    <= rd_addr_d;
            beat_q       <= beat_d;
        end
    end

    pp_bank_ram #(
        .WIDTH (DIN_W),
        .AW    (AW),
        .BW    (BW),
        .NBANK (NBANK)
    ) u_ram (
        .clk_i   (clk_i),
        .we_i    (wr_en),
        .wbank_i (wr_bank_q),
        .waddr_i (wr_addr_q),
        .wdata_i (in_data_i),
        .re_i    (ram_re),
        .rbank_i (rd_bank_q),
        .raddr_i (ram_raddr),
        .rdata_o (ram_rdata)
    );

    // Beat k presents slice RATIO-1-k of the held word.
    assign slice_idx   = LastBeat - beat_q;
    assign slice_shift = 32'(slice_idx) * DOUT_W;
    assign shifted     = ram_rdata >> slice_shift;

    assign in_ready_o   = DROP_MODE ? 1'b1 : wr_bank_free;
    assign out_valid_o  = streaming;
    assign out_data_o   = streaming ? shifted[DOUT_W-1:0] : '0;
    assign out_last_o   = streaming & (beat_q == LastBeat) & (rd_addr_q == LastAddr);
    assign wr_bank_o    = wr_bank_q;
    assign rd_bank_o    = rd_bank_q;
    assign banks_full_o = full_cnt_q;
    assign ovf_cnt_o    = ovf_cnt_q;

endmodule

// File: tb/tb_pingpong_stream_buf.sv
// Directed bench for pingpong_stream_buf: one stall-mode and one drop-mode instance,
// DIN_W=32, DOUT_W=8, DEPTH=4, NBANK=2.
module tb_pingpong_stream_buf;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clr = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        out_ready = 1'b0;
    logic        sel = 1'b0;

    logic        in_valid0, in_valid1;
    logic        in_ready0, in_ready1, out_valid0, out_valid1, out_last0, out_last1;
    logic [7:0]  out_data0, out_data1;
    logic [0:0]  wr_bank0, wr_bank1, rd_bank0, rd_bank1;
    logic [1:0]  banks_full0, banks_full1;
    logic [15:0] ovf0, ovf1;

    logic        in_ready_s, out_valid_s, out_last_s;
    logic [7:0]  out_data_s;
    logic [0:0]  wr_bank_s, rd_bank_s;
    logic [1:0]  banks_full_s;
    logic [15:0] ovf_s;

    int          n_vec = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic [7:0]  beats[$];
    bit          lasts[$];
    logic [31:0] exp_w[$];
    bit          seen_v = 1'b0;
    int          first_v_cyc = 0;
    int          last_hs_cyc = 0;

    always #5 clk = ~clk;

    assign in_valid0 = in_valid & ~sel;
    assign in_valid1 = in_valid & sel;

    assign in_ready_s   = sel ? in_ready1   : in_ready0;
    assign out_valid_s  = sel ? out_valid1  : out_valid0;
    assign out_last_s   = sel ? out_last1   : out_last0;
    assign out_data_s   = sel ? out_data1   : out_data0;
    assign wr_bank_s    = sel ? wr_bank1    : wr_bank0;
    assign rd_bank_s    = sel ? rd_bank1    : rd_bank0;
    assign banks_full_s = sel ? banks_full1 : banks_full0;
    assign ovf_s        = sel ? ovf1        : ovf0;

    pingpong_stream_buf #(
        .DIN_W(32), .DOUT_W(8), .DEPTH(4), .NBANK(2), .DROP_MODE(1'b0)
    ) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .in_valid_i(in_valid0), .in_data_i(in_data), .in_ready_o(in_ready0),
        .out_valid_o(out_valid0), .out_data_o(out_data0), .out_ready_i(out_ready),
        .out_last_o(out_last0), .wr_bank_o(wr_bank0), .rd_bank_o(rd_bank0),
        .banks_full_o(banks_full0), .ovf_cnt_o(ovf0)
    );

    pingpong_stream_buf #(
        .DIN_W(32), .DOUT_W(8), .DEPTH(4), .NBANK(2), .DROP_MODE(1'b1)
    ) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .clr_i(clr),
        .in_valid_i(in_valid1), .in_data_i(in_data), .in_ready_o(in_ready1),
        .out_valid_o(out_valid1), .out_data_o(out_data1), .out_ready_i(out_ready),
        .out_last_o(out_last1), .wr_bank_o(wr_bank1), .rd_bank_o(rd_bank1),
        .banks_full_o(banks_full1), .ovf_cnt_o(ovf1)
    );

    // cyc equals the number of the most recent rising edge.
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst_n && out_valid_s) begin
            if (!seen_v) begin
                seen_v      = 1'b1;
                first_v_cyc = cyc;
            end
            if (out_ready) begin
                beats.push_back(out_data_s);
                lasts.push_back(out_last_s);
                if (out_last_s) last_hs_cyc = cyc;
            end
        end
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] word_of(input int n);
        logic [7:0] b;
        b = 8'(n * 16);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    task automatic clear_mon();
        beats.delete();
        lasts.delete();
        exp_w.delete();
        seen_v = 1'b0;
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        out_ready = 1'b0;
        clr       = 1'b0;
        in_data   = '0;
        rst_n     = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(1);
        clear_mon();
    endtask

    // Hold in_valid until the selected DUT takes the word; returns the accepting edge.
    task automatic put_word(input logic [31:0] w, output int edge_no);
        bit acc;
        acc      = 1'b0;
        in_valid = 1'b1;
        in_data  = w;
        for (int i = 0; i < 300 && !acc; i++) begin
            @(negedge clk);
            acc = in_ready_s;
            @(posedge clk);
            #1;
        end
        edge_no  = cyc;
        in_valid = 1'b0;
        if (!acc) check_val("put_timeout", 32'd0, 32'd1);
    endtask

    task automatic wait_beats(input string tag, input int n);
        for (int i = 0; i < 500 && beats.size() < n; i++) step(1);
        check_val({tag, "_nbeats"}, beats.size(), n);
    endtask

    task automatic check_frame(input string tag);
        logic [31:0] w;
        logic [7:0]  eb;
        for (int i = 0; i < exp_w.size() * 4 && i < beats.size(); i++) begin
            w  = exp_w[i / 4];
            eb = w[31 - 8 * (i % 4) -: 8];
            check_val($sformatf("%s_b%0d", tag, i), {24'd0, beats[i]}, {24'd0, eb});
            check_val($sformatf("%s_l%0d", tag, i), {31'd0, lasts[i]},
                      {31'd0, ((i % 16) == 15)});
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int e;
        int e4;
        int n_last;

        // Reset state
        do_reset();
        check_val("rst_in_ready0", in_ready0, 1);
        check_val("rst_in_ready1", in_ready1, 1);
        check_val("rst_out_valid", out_valid0, 0);
        check_val("rst_out_last", out_last0, 0);
        check_val("rst_out_data", out_data0, 0);
        check_val("rst_wr_bank", wr_bank0, 0);
        check_val("rst_rd_bank", rd_bank0, 0);
        check_val("rst_banks_full", banks_full0, 0);
        check_val("rst_ovf", ovf1, 0);

        // 1: single frame, latency and slice order
        sel       = 1'b0;
        out_ready = 1'b1;
        exp_w     = '{32'h11223344, 32'h55667788, 32'h99AABBCC, 32'hDDEEFF00};
        e4        = 0;
        for (int k = 0; k < 4; k++) put_word(exp_w[k], e4);
        wait_beats("t1", 16);
        check_val("t1_latency", first_v_cyc - e4, 2);
        check_frame("t1");
        step(2);
        check_val("t1_banks_full", banks_full_s, 0);
        check_val("t1_rd_bank", rd_bank_s, 1);
        check_val("t1_wr_bank", wr_bank_s, 1);

        // 2: steady writes, bank toggling, no input stall
        do_reset();
        sel       = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 16; k++) begin
            check_val($sformatf("t2_rdy%0d", k), in_ready_s, 1);
            check_val($sformatf("t2_wrb%0d", k), wr_bank_s, (k / 4) % 2);
            exp_w.push_back(word_of(k));
            put_word(word_of(k), e);
            step(4);
        end
        wait_beats("t2", 64);
        check_frame("t2");

        // 3: stall mode, both banks full, word 9 waits for bank 0 to free
        do_reset();
        sel       = 1'b0;
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_w.push_back(word_of(k));
            put_word(word_of(k), e);
        end
        step(2);
        check_val("t3_banks_full", banks_full_s, 2);
        check_val("t3_in_ready", in_ready_s, 0);
        check_val("t3_out_valid", out_valid_s, 1);
        check_val("t3_hold_data0", out_data_s, 8'h10);
        check_val("t3_hold_last", out_last_s, 0);
        in_valid = 1'b1;
        in_data  = word_of(9);
        step(3);
        check_val("t3_still_stalled", in_ready_s, 0);
        check_val("t3_hold_data1", out_data_s, 8'h10);
        out_ready = 1'b1;
        put_word(word_of(9), e);
        check_val("t3_w9_after_free", e - (last_hs_cyc + 1), 1);
        wait_beats("t3", 32);
        check_frame("t3");

        // 4: drop mode, word 9 discarded
        do_reset();
        sel       = 1'b1;
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_w.push_back(word_of(k));
            put_word(word_of(k), e);
        end
        step(2);
        check_val("t4_banks_full", banks_full_s, 2);
        check_val("t4_in_ready", in_ready_s, 1);
        check_val("t4_ovf0", ovf_s, 0);
        put_word(word_of(9), e);
        check_val("t4_ovf1", ovf_s, 1);
        check_val("t4_wr_bank", wr_bank_s, 0);
        out_ready = 1'b1;
        wait_beats("t4", 32);
        check_frame("t4");
        step(2);
        check_val("t4_drained", banks_full_s, 0);

        // 5: clr mid-drain (drop instance, ovf still 1)
        clear_mon();
        out_ready = 1'b1;
        for (int k = 10; k <= 13; k++) put_word(word_of(k), e);
        for (int i = 0; i < 100 && beats.size() < 6; i++) step(1);
        check_val("t5_reached_b6", beats.size(), 6);
        clr = 1'b1;
        step(1);
        clr = 1'b0;
        check_val("t5_out_valid", out_valid_s, 0);
        check_val("t5_banks_full", banks_full_s, 0);
        check_val("t5_ovf", ovf_s, 0);
        check_val("t5_rd_bank", rd_bank_s, 0);
        check_val("t5_wr_bank", wr_bank_s, 0);
        step(3);
        n_last = 0;
        foreach (lasts[i]) n_last += int'(lasts[i]);
        check_val("t5_no_last", n_last, 0);
        check_val("t5_quiet", out_valid_s, 0);
        clear_mon();
        for (int k = 4; k <= 7; k++) begin
            exp_w.push_back(word_of(k));
            put_word(word_of(k), e);
        end
        wait_beats("t5", 16);
        check_frame("t5");

        // 6: overflow counter saturation
        do_reset();
        sel       = 1'b1;
        out_ready = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            exp_w.push_back(word_of(k));
            put_word(word_of(k), e);
        end
        step(2);
        force dut1.ovf_cnt_q = 16'hFFFE;
        step(1);
        release dut1.ovf_cnt_q;
        step(1);
        check_val("t6_ovf_fffe", ovf_s, 16'hFFFE);
        put_word(word_of(9), e);
        check_val("t6_ovf_sat1", ovf_s, 16'hFFFF);
        put_word(word_of(10), e);
        put_word(word_of(11), e);
        check_val("t6_ovf_sat3", ovf_s, 16'hFFFF);
        check_val("t6_banks_full", banks_full_s, 2);
        out_ready = 1'b1;
        wait_beats("t6", 32);
        check_frame("t6");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
